// File: rtl/vp_arbiter.sv
// vp_arbiter: round-robin arbiter that shares one vector processor among
// NUM_REQ requesters, one transaction at a time.
//
// Ports
//   clk, rst            clock (rising edge), asynchronous active-high reset
//   req_valid/op/vec_a/vec_b/scalar
//                       per-requester request, packed by requester index
//   req_accept          one-hot, one-cycle acceptance pulse
//   rsp_valid/id/data/timeout
//                       one-cycle response; timeout responses carry zero data
//   vp_start/operation/vec_a/vec_b/scalar
//                       command to the vector processor; operands hold until
//                       the next issue
//   vp_busy/result/result_valid
//                       vector processor status
//   timeout_count       saturating count of timed-out transactions
module vp_arbiter #(
  parameter int DATA_WIDTH     = 16,
  parameter int VECTOR_WIDTH   = 4,
  parameter int NUM_REQ        = 4,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                                      clk,
  input  logic                                      rst,
  input  logic [NUM_REQ-1:0]                        req_valid,
  input  logic [4*NUM_REQ-1:0]                      req_op,
  input  logic [VECTOR_WIDTH*DATA_WIDTH*NUM_REQ-1:0] req_vec_a,
  input  logic [VECTOR_WIDTH*DATA_WIDTH*NUM_REQ-1:0] req_vec_b,
  input  logic [DATA_WIDTH*NUM_REQ-1:0]             req_scalar,
  output logic [NUM_REQ-1:0]                        req_accept,
  output logic                                      rsp_valid,
  output logic [2:0]                                rsp_id,
  output logic [VECTOR_WIDTH*DATA_WIDTH-1:0]        rsp_data,
  output logic                                      rsp_timeout,
  output logic                                      vp_start,
  output logic [3:0]                                vp_operation,
  output logic [VECTOR_WIDTH*DATA_WIDTH-1:0]        vp_vec_a,
  output logic [VECTOR_WIDTH*DATA_WIDTH-1:0]        vp_vec_b,
  output logic [DATA_WIDTH-1:0]                     vp_scalar,
  input  logic                                      vp_busy,
  input  logic [VECTOR_WIDTH*DATA_WIDTH-1:0]        vp_result,
  input  logic                                      vp_result_valid,
  output logic [7:0]                                timeout_count
);

  localparam int          V  = VECTOR_WIDTH * DATA_WIDTH;
  localparam int unsigned NR = NUM_REQ;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT
  } state_t;

  state_t                  state, state_d;
  logic [2:0]              last_grant, last_grant_d;
  logic [7:0]              timer, timer_d;
  logic [3:0]              cap_op, cap_op_d;
  logic [V-1:0]            cap_a, cap_a_d;
  logic [V-1:0]            cap_b, cap_b_d;
  logic [DATA_WIDTH-1:0]   cap_s, cap_s_d;

  logic [NUM_REQ-1:0]      req_accept_d;
  logic                    rsp_valid_d;
  logic [2:0]              rsp_id_d;
  logic [V-1:0]            rsp_data_d;
  logic                    rsp_timeout_d;
  logic                    vp_start_d;
  logic [3:0]              vp_operation_d;
  logic [V-1:0]            vp_vec_a_d;
  logic [V-1:0]            vp_vec_b_d;
  logic [DATA_WIDTH-1:0]   vp_scalar_d;
  logic [7:0]              timeout_count_d;

  // Round-robin pick: first requester at or after last_grant+1 (mod NUM_REQ).
  logic                    pick_found;
  logic [2:0]              pick;
  logic [3:0]              pick_op;
  logic [V-1:0]            pick_a;
  logic [V-1:0]            pick_b;
  logic [DATA_WIDTH-1:0]   pick_s;

  always_comb begin
    int unsigned idx;
    idx        = 0;
    pick_found = 1'b0;
    pick       = '0;
    pick_op    = '0;
    pick_a     = '0;
    pick_b     = '0;
    pick_s     = '0;
    for (int unsigned k = 1; k <= NR; k++) begin
      idx = (32'(last_grant) + k) % NR;
      if (!pick_found && req_valid[idx]) begin
        pick_found = 1'b1;
        pick       = 3'(idx);
        pick_op    = req_op[idx*4 +: 4];
        pick_a     = req_vec_a[idx*V +: V];
        pick_b     = req_vec_b[idx*V +: V];
        pick_s     = req_scalar[idx*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  always_comb begin
    state_d         = state;
    last_grant_d    = last_grant;
    timer_d         = timer;
    cap_op_d        = cap_op;
    cap_a_d         = cap_a;
    cap_b_d         = cap_b;
    cap_s_d         = cap_s;
    req_accept_d    = '0;
    rsp_valid_d     = 1'b0;
    rsp_id_d        = rsp_id;
    rsp_data_d      = rsp_data;
    rsp_timeout_d   = 1'b0;
    vp_start_d      = 1'b0;
    vp_operation_d  = vp_operation;
    vp_vec_a_d      = vp_vec_a;
    vp_vec_b_d      = vp_vec_b;
    vp_scalar_d     = vp_scalar;
    timeout_count_d = timeout_count;

    case (state)
      ST_IDLE: begin
        if (pick_found) begin
          req_accept_d = NUM_REQ'(1) << pick;
          last_grant_d = pick;
          cap_op_d     = pick_op;
          cap_a_d      = pick_a;
          cap_b_d      = pick_b;
          cap_s_d      = pick_s;
          state_d      = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        if (!vp_busy) begin
          vp_start_d     = 1'b1;
          vp_operation_d = cap_op;
          vp_vec_a_d     = cap_a;
          vp_vec_b_d     = cap_b;
          vp_scalar_d    = cap_s;
          timer_d        = '0;
          state_d        = ST_WAIT;
        end
      end
      ST_WAIT: begin
        // A result on the limit cycle takes priority over the timeout.
        if (vp_result_valid) begin
          rsp_valid_d = 1'b1;
          rsp_id_d    = last_grant;
          rsp_data_d  = vp_result;
          state_d     = ST_IDLE;
        end else if (({1'b0, timer} + 9'd1) == 9'(TIMEOUT_CYCLES)) begin
          rsp_valid_d   = 1'b1;
          rsp_id_d      = last_grant;
          rsp_data_d    = '0;
          rsp_timeout_d = 1'b1;
          timer_d       = timer + 8'd1;
          if (timeout_count != 8'hFF) begin
            timeout_count_d = timeout_count + 8'd1;
          end
          state_d = ST_IDLE;
        end else begin
          timer_d = timer + 8'd1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= ST_IDLE;
      last_grant    <= 3'(NUM_REQ - 1);
      timer         <= '0;
      cap_op        <= '0;
      cap_a         <= '0;
      cap_b         <= '0;
      cap_s         <= '0;
      req_accept    <= '0;
      rsp_valid     <= 1'b0;
      rsp_id        <= '0;
      rsp_data      <= '0;
      rsp_timeout   <= 1'b0;
      vp_start      <= 1'b0;
      vp_operation  <= '0;
      vp_vec_a      <= '0;
      vp_vec_b      <= '0;
      vp_scalar     <= '0;
      timeout_count <= '0;
    end else begin
      state         <= state_d;
      last_grant    <= last_grant_d;
      timer         <= timer_d;
      cap_op        <= cap_op_d;
      cap_a         <= cap_a_d;
      cap_b         <= cap_b_d;
      cap_s         <= cap_s_d;
      req_accept    <= req_accept_d;
      rsp_valid     <= rsp_valid_d;
      rsp_id        <= rsp_id_d;
      rsp_data      <= rsp_data_d;
      rsp_timeout   <= rsp_timeout_d;
      vp_start      <= vp_start_d;
      vp_operation  <= vp_operation_d;
      vp_vec_a      <= vp_vec_a_d;
      vp_vec_b      <= vp_vec_b_d;
      vp_scalar     <= vp_scalar_d;
      timeout_count <= timeout_count_d;
    end
  end

endmodule

// File: tb/tb_vp_arbiter.sv
module tb_vp_arbiter;

  localparam int DW = 16;
  localparam int VW = 4;
  localparam int NR = 4;
  localparam int TO = 8;
  localparam int V  = DW * VW;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [NR-1:0]     req_valid = '0;
  logic [4*NR-1:0]   req_op = '0;
  logic [V*NR-1:0]   req_vec_a = '0;
  logic [V*NR-1:0]   req_vec_b = '0;
  logic [DW*NR-1:0]  req_scalar = '0;
  logic [NR-1:0]     req_accept;
  logic              rsp_valid;
  logic [2:0]        rsp_id;
  logic [V-1:0]      rsp_data;
  logic              rsp_timeout;
  logic              vp_start;
  logic [3:0]        vp_operation;
  logic [V-1:0]      vp_vec_a;
  logic [V-1:0]      vp_vec_b;
  logic [DW-1:0]     vp_scalar;
  logic              vp_busy = 1'b0;
  logic [V-1:0]      vp_result = '0;
  logic              vp_result_valid = 1'b0;
  logic [7:0]        timeout_count;

  vp_arbiter #(
    .DATA_WIDTH(DW),
    .VECTOR_WIDTH(VW),
    .NUM_REQ(NR),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk),
    .rst(rst),
    .req_valid(req_valid),
    .req_op(req_op),
    .req_vec_a(req_vec_a),
    .req_vec_b(req_vec_b),
    .req_scalar(req_scalar),
    .req_accept(req_accept),
    .rsp_valid(rsp_valid),
    .rsp_id(rsp_id),
    .rsp_data(rsp_data),
    .rsp_timeout(rsp_timeout),
    .vp_start(vp_start),
    .vp_operation(vp_operation),
    .vp_vec_a(vp_vec_a),
    .vp_vec_b(vp_vec_b),
    .vp_scalar(vp_scalar),
    .vp_busy(vp_busy),
    .vp_result(vp_result),
    .vp_result_valid(vp_result_valid),
    .timeout_count(timeout_count)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Requester-side model: pending mask and the operands each requester offers.
  logic [NR-1:0] pend = '0;
  logic [3:0]    m_op [NR];
  logic [V-1:0]  m_a  [NR];
  logic [V-1:0]  m_b  [NR];
  logic [DW-1:0] m_s  [NR];

  // Expected arbiter-visible state.
  int            exp_last = NR - 1;
  int            exp_tc   = 0;
  logic [3:0]    e_op = '0;
  logic [V-1:0]  e_a  = '0;
  logic [V-1:0]  e_b  = '0;
  logic [DW-1:0] e_s  = '0;

  task automatic chk(input string tag, input logic [V-1:0] obs, input logic [V-1:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic new_req(input int i);
    m_op[i] = 4'($urandom);
    m_a[i]  = {$urandom, $urandom};
    m_b[i]  = {$urandom, $urandom};
    m_s[i]  = DW'($urandom);
  endtask

  task automatic drive_reqs();
    for (int i = 0; i < NR; i++) begin
      req_op[4*i +: 4]     = m_op[i];
      req_vec_a[V*i +: V]  = m_a[i];
      req_vec_b[V*i +: V]  = m_b[i];
      req_scalar[DW*i +: DW] = m_s[i];
    end
    req_valid = pend;
  endtask

  function automatic int rr_pick(input logic [NR-1:0] p, input int last);
    for (int k = 1; k <= NR; k++) begin
      if (p[(last + k) % NR]) return (last + k) % NR;
    end
    return -1;
  endfunction

  task automatic chk_reset(input string tag);
    chk({tag, "_accept"},  req_accept, '0);
    chk({tag, "_rsp_valid"}, rsp_valid, '0);
    chk({tag, "_rsp_id"},  rsp_id, '0);
    chk({tag, "_rsp_data"}, rsp_data, '0);
    chk({tag, "_rsp_timeout"}, rsp_timeout, '0);
    chk({tag, "_vp_start"}, vp_start, '0);
    chk({tag, "_vp_op"},   vp_operation, '0);
    chk({tag, "_vp_a"},    vp_vec_a, '0);
    chk({tag, "_vp_b"},    vp_vec_b, '0);
    chk({tag, "_vp_s"},    vp_scalar, '0);
    chk({tag, "_tcount"},  timeout_count, '0);
  endtask

  // Cycles with no request offered; stray processor results must be ignored.
  task automatic idle_cycles(input int n);
    req_valid = '0;
    for (int c = 0; c < n; c++) begin
      vp_result_valid = 1'($urandom_range(0, 1));
      vp_result       = {$urandom, $urandom};
      step();
      chk("idle_accept", req_accept, '0);
      chk("idle_rsp", rsp_valid, '0);
      chk("idle_start", vp_start, '0);
    end
    vp_result_valid = 1'b0;
    drive_reqs();
  endtask

  // One transaction starting from IDLE. busy: ISSUE cycles with vp_busy high.
  // d: cycle offset (after the vp_start cycle) at which the processor raises
  // vp_result_valid, or -1 for never. keep: requester re-requests at once.
  task automatic do_txn(input int busy, input int d, input bit keep);
    int            g;
    int            kr;
    bit            tmo;
    logic [3:0]    op;
    logic [V-1:0]  a, b, rv;
    logic [DW-1:0] s;
    logic [NR-1:0] onehot;

    if (pend == '0) pend[$urandom_range(0, NR-1)] = 1'b1;
    drive_reqs();
    g  = rr_pick(pend, exp_last);
    op = m_op[g];
    a  = m_a[g];
    b  = m_b[g];
    s  = m_s[g];
    rv = '0;
    onehot    = '0;
    onehot[g] = 1'b1;

    step();
    chk("accept", req_accept, onehot);
    chk("accept_no_start", vp_start, '0);
    chk("accept_no_rsp", rsp_valid, '0);
    exp_last = g;
    if (!keep) pend[g] = 1'b0;
    new_req(g);
    drive_reqs();

    vp_busy = (busy > 0);
    for (int n = 0; n < busy; n++) begin
      vp_result_valid = 1'($urandom_range(0, 1));
      vp_result       = {$urandom, $urandom};
      step();
      chk("busy_no_start", vp_start, '0);
      chk("busy_no_rsp", rsp_valid, '0);
      chk("busy_no_accept", req_accept, '0);
      chk("busy_hold_op", vp_operation, e_op);
      chk("busy_hold_a", vp_vec_a, e_a);
      if (n == busy - 1) vp_busy = 1'b0;
    end

    vp_result_valid = 1'($urandom_range(0, 1));
    step();
    chk("start", vp_start, 1'b1);
    chk("start_op", vp_operation, op);
    chk("start_a", vp_vec_a, a);
    chk("start_b", vp_vec_b, b);
    chk("start_s", vp_scalar, s);
    chk("start_no_rsp", rsp_valid, '0);
    e_op = op;
    e_a  = a;
    e_b  = b;
    e_s  = s;

    tmo = !(d >= 0 && d + 1 <= TO);
    kr  = tmo ? TO : d + 1;
    for (int k = 1; k <= kr; k++) begin
      vp_result_valid = (d == k - 1);
      if (d == k - 1) begin
        rv        = {$urandom, $urandom};
        vp_result = rv;
      end else begin
        vp_result = {$urandom, $urandom};
      end
      step();
      chk("wait_no_start", vp_start, '0);
      chk("wait_hold_s", vp_scalar, e_s);
      chk("wait_hold_b", vp_vec_b, e_b);
      if (k < kr) begin
        chk("wait_no_rsp", rsp_valid, '0);
      end else begin
        if (tmo && exp_tc < 255) exp_tc++;
        chk("rsp_valid", rsp_valid, 1'b1);
        chk("rsp_id", rsp_id, V'(g));
        chk("rsp_timeout", rsp_timeout, tmo);
        chk("rsp_data", rsp_data, tmo ? '0 : rv);
        chk("tcount", timeout_count, V'(exp_tc));
      end
    end
    vp_result_valid = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin
    for (int i = 0; i < NR; i++) new_req(i);
    drive_reqs();

    // Reset values while reset is held.
    step();
    chk_reset("reset");
    step();
    rst = 1'b0;
    idle_cycles(2);

    // All four requesting continuously, result 2 cycles after each start.
    pend = '1;
    for (int n = 0; n < 5; n++) do_txn(0, 2, 1'b1);

    // Single request with the processor busy for 5 cycles.
    pend = '0;
    idle_cycles(2);
    pend     = 4'b0010;
    m_op[1]  = 4'd4;
    m_s[1]   = 16'h0100;
    do_txn(5, 1, 1'b0);

    // No result ever returned: timeout exactly TO cycles after vp_start.
    pend = 4'b0100;
    do_txn(0, -1, 1'b0);
    // Result on the very cycle the timer hits the limit.
    pend = 4'b1000;
    do_txn(0, TO - 1, 1'b0);
    // Result one cycle too late is a timeout.
    pend = 4'b0001;
    do_txn(1, TO, 1'b0);

    // Randomized traffic.
    for (int n = 0; n < 40; n++) begin
      int dsel;
      pend = pend | NR'($urandom);
      dsel = $urandom_range(0, 5);
      do_txn($urandom_range(0, 3), (dsel == 0) ? -1 : $urandom_range(1, TO + 1), 1'($urandom_range(0, 1)));
      if ($urandom_range(0, 3) == 0) idle_cycles($urandom_range(1, 3));
    end

    // Drive timeout_count into saturation.
    for (int n = 0; n < 260; n++) begin
      pend = NR'($urandom);
      do_txn(0, -1, 1'b0);
    end
    chk("tcount_saturated", timeout_count, 8'hFF);

    // Reset while in WAIT, then a stray result after reset.
    pend = 4'b0100;
    drive_reqs();
    begin
      logic [NR-1:0] oh;
      oh = '0;
      oh[rr_pick(pend, exp_last)] = 1'b1;
      step();
      chk("rst_seq_accept", req_accept, oh);
    end
    pend = '0;
    drive_reqs();
    vp_busy = 1'b0;
    step();
    chk("rst_seq_start", vp_start, 1'b1);
    step();
    step();
    chk("rst_seq_waiting", rsp_valid, '0);
    #2;
    rst = 1'b1;
    #1;
    chk_reset("async_reset");
    step();
    chk_reset("held_reset");
    rst = 1'b0;
    vp_result_valid = 1'b1;
    vp_result       = {$urandom, $urandom};
    step();
    chk("stray_rsp0", rsp_valid, '0);
    step();
    chk("stray_rsp1", rsp_valid, '0);
    vp_result_valid = 1'b0;
    exp_last = NR - 1;
    exp_tc   = 0;
    e_op = '0;
    e_a  = '0;
    e_b  = '0;
    e_s  = '0;
    pend = '1;
    do_txn(0, 2, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/vp_arbiter.md
VP_ARBITER -- requirements
Module: vp_arbiter

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 16, vector element width.
REQ-002 SHALL have parameter VECTOR_WIDTH, default 4, elements per vector; V = VECTOR_WIDTH*DATA_WIDTH.
REQ-003 SHALL have parameter NUM_REQ, default 4, number of requesters (2..8).
REQ-004 SHALL have parameter TIMEOUT_CYCLES, default 255, maximum WAIT cycles (1..255).
REQ-005 SHALL have port clk, input, 1, single clock, all logic on rising edge.
REQ-006 SHALL have port rst, input, 1, asynchronous, active-high reset.
REQ-007 SHALL have port req_valid, input, NUM_REQ, per-requester request, held until accepted.
REQ-008 SHALL have port req_op, input, 4*NUM_REQ, operation code; requester i at bits [4i+3:4i].
REQ-009 SHALL have port req_vec_a, input, V*NUM_REQ, operand A; requester i at slice i.
REQ-010 SHALL have port req_vec_b, input, V*NUM_REQ, operand B; requester i at slice i.
REQ-011 SHALL have port req_scalar, input, DATA_WIDTH*NUM_REQ, scalar operand; requester i at slice i.
REQ-012 SHALL have port req_accept, output, NUM_REQ, one-hot, one-cycle acceptance pulse.
REQ-013 SHALL have port rsp_valid, output, 1, one-cycle response pulse.
REQ-014 SHALL have port rsp_id, output, 3, index of the responding requester.
REQ-015 SHALL have port rsp_data, output, V, result vector.
REQ-016 SHALL have port rsp_timeout, output, 1, response was generated by timeout.
REQ-017 SHALL have ports vp_start (out, 1), vp_operation (out, 4), vp_vec_a (out, V), vp_vec_b (out, V), vp_scalar (out, DATA_WIDTH), vector processor command.
REQ-018 SHALL have ports vp_busy (in, 1), vp_result (in, V), vp_result_valid (in, 1), vector processor status.
REQ-019 SHALL have port timeout_count, output, 8, saturating count of timeouts.

Function
REQ-020 SHALL implement states IDLE, ISSUE, WAIT; all outputs registered.
REQ-021 IDLE with any req_valid bit set: at the clock edge, SHALL select grant g round-robin, starting from last_grant+1 and wrapping modulo NUM_REQ.
REQ-022 At that same edge: capture op/vec_a/vec_b/scalar of g; pulse req_accept[g] for 1 cycle; set last_grant=g; go to ISSUE.
REQ-023 IDLE with req_valid all zero: SHALL stay in IDLE; last_grant unchanged.
REQ-024 ISSUE with vp_busy=0: SHALL drive captured operands on vp_* buses, pulse vp_start for exactly 1 cycle, clear the timer, go to WAIT.
REQ-025 ISSUE with vp_busy=1: SHALL stay in ISSUE with vp_start=0, indefinitely; no timeout applies in ISSUE.
REQ-026 vp_operation/vp_vec_a/vp_vec_b/vp_scalar SHALL hold their values from issue until the next issue.
REQ-027 WAIT with vp_result_valid=1: rsp_data=vp_result, rsp_id=grant, rsp_timeout=0, rsp_valid pulse; go to IDLE.
REQ-028 WAIT without a result: timer +1 per cycle; when timer reaches TIMEOUT_CYCLES: rsp_data=0, rsp_timeout=1, rsp_valid pulse, timeout_count+1 (saturates at 255); go to IDLE.
REQ-029 vp_result_valid coincident with the timeout cycle: result SHALL win; no timeout recorded.
REQ-030 vp_result_valid in IDLE or ISSUE SHALL be ignored; there SHALL be no response.
REQ-031 Minimum turnaround SHALL be 3 cycles: accept -> vp_start -> result earliest next cycle -> rsp_valid; next accept no earlier than the cycle after rsp_valid.
REQ-032 At most one transaction SHALL be outstanding; req_valid is not sampled outside IDLE.
REQ-033 rsp_id SHALL equal g zero-extended to 3 bits.

Reset
REQ-034 rst=1 SHALL force IDLE asynchronously, including mid-transaction; the in-flight transaction is dropped with no response.
REQ-035 Reset values: req_accept=0, rsp_valid=0, rsp_id=0, rsp_data=0, rsp_timeout=0, vp_start=0, vp_operation=0, vp_vec_a=0, vp_vec_b=0, vp_scalar=0, timeout_count=0, timer=0, last_grant=NUM_REQ-1 (requester 0 has first priority).

Verification
REQ-036 Setup: req_valid=4'b1111 held continuously; processor returns a result 2 cycles after each start. Required: accept order 0,1,2,3,0; each rsp_id matches its accept.
REQ-037 Setup: single request, op=4, scalar=0x0100, vp_busy=1 for 5 cycles. Required: vp_start stays low for 5 cycles, then pulses once carrying op=4, scalar=0x0100.
REQ-038 Setup: TIMEOUT_CYCLES=8; no result is ever returned. Required: rsp_valid with rsp_timeout=1 and rsp_data=0 exactly 8 cycles after vp_start; timeout_count=1.
REQ-039 Setup: result arrives on the same cycle the timer hits the limit. Required: rsp_timeout=0, rsp_data=vp_result, timeout_count unchanged.
REQ-040 Setup: rst asserted while in WAIT, then a stray vp_result_valid after reset. Required: all outputs at reset values immediately; no rsp_valid; the next accept goes to requester 0.
